// File: rtl/game2048_pkg.sv
// Shared types and constants for the 2048 game datapath.
// Optional feature macro: BOARD_SHIFT_SCORE_EN (merge score accounting).
package game2048_pkg;

  localparam int unsigned CELL_W       = 4;
  localparam int unsigned BOARD_W      = 64;
  localparam int unsigned LINE_N       = 4;
  localparam int unsigned LINE_W       = CELL_W * LINE_N;
  localparam int unsigned SCORE_W      = 16;
  // Two merges per line, each worth at most 2^16, fit in 18 bits.
  localparam int unsigned LINE_SCORE_W = 18;

  typedef enum logic [1:0] {
    DIR_UP,
    DIR_DOWN,
    DIR_LEFT,
    DIR_RIGHT
  } dir_e;

  typedef enum logic [2:0] {
    IDLE,
    LINE0,
    LINE1,
    LINE2,
    LINE3,
    COMMIT
  } state_e;

  // Bit offset of cell (row, col): CELL_W * (LINE_N*row + col).
  function automatic logic [5:0] cell_off(input logic [1:0] row, input logic [1:0] col);
    return {row, col, 2'b00};
  endfunction

  // Add a line score to the move accumulator, saturating at all-ones.
  function automatic logic [SCORE_W-1:0] score_sat_add(input logic [SCORE_W-1:0]      acc,
                                                       input logic [LINE_SCORE_W-1:0] inc);
    logic [LINE_SCORE_W:0] sum;
    sum = {{(LINE_SCORE_W - SCORE_W + 1){1'b0}}, acc} + {1'b0, inc};
    return (sum[LINE_SCORE_W:SCORE_W] != '0) ? '1 : sum[SCORE_W-1:0];
  endfunction

endpackage

// File: rtl/line_merge.sv
// Combinational slide-and-merge of one 4-cell line, leading cell at bits [3:0].
// With BOARD_SHIFT_SCORE_EN defined, also reports the line's merge score.
module line_merge
  import game2048_pkg::*;
#(
  parameter int unsigned MAX_EXP = 15
) (
  input  logic [LINE_W-1:0]       line_in,
  output logic [LINE_W-1:0]       line_out
`ifdef BOARD_SHIFT_SCORE_EN
  ,
  output logic [LINE_SCORE_W-1:0] line_score
`endif
);

  localparam logic [CELL_W:0] MAX_E = MAX_EXP[CELL_W:0];
  localparam logic [CELL_W:0] E_ONE = 1;

  logic [CELL_W-1:0] comp_c  [LINE_N];
  logic [CELL_W-1:0] out_c   [LINE_N];
  logic [LINE_N-1:0] pair_eq;

  // Compact non-zero cells toward the leading edge, preserving their order.
  always_comb begin
    logic [2:0] wr;
    // NOTE: every variable gets a value before any conditional write, so no latch is inferred.
    wr = '0;
    for (int i = 0; i < LINE_N; i++) comp_c[i] = '0;
    for (int i = 0; i < LINE_N; i++) begin
      if (line_in[CELL_W*i +: CELL_W] != '0) begin
        comp_c[wr[1:0]] = line_in[CELL_W*i +: CELL_W];
        wr              = wr + 3'd1;
      end
    end
  end

  // Flag adjacent equal non-empty pairs; the last slot never starts a pair.
  always_comb begin
    pair_eq = '0;
    for (int i = 0; i < LINE_N - 1; i++) begin
      pair_eq[i] = (comp_c[i] != '0) && (comp_c[i] == comp_c[i+1]);
    end
  end

  // Scan from the leading edge; a merged pair consumes both cells so no tile merges twice.
  always_comb begin
    logic [2:0]        wr;
    logic              skip;
    logic [CELL_W:0]   bumped;
    wr     = '0;
    skip   = 1'b0;
    bumped = '0;
    for (int i = 0; i < LINE_N; i++) out_c[i] = '0;
`ifdef BOARD_SHIFT_SCORE_EN
    line_score = '0;
`endif
    for (int i = 0; i < LINE_N; i++) begin
      if (skip) begin
        skip = 1'b0;
      end else if (pair_eq[i]) begin
        bumped          = {1'b0, comp_c[i]} + E_ONE;
        out_c[wr[1:0]]  = (bumped > MAX_E) ? MAX_E[CELL_W-1:0] : bumped[CELL_W-1:0];
`ifdef BOARD_SHIFT_SCORE_EN
        // Score uses the unsaturated exponent; the accumulator saturates instead.
        line_score      = line_score + (LINE_SCORE_W'(1) << bumped);
`endif
        skip            = 1'b1;
        wr              = wr + 3'd1;
      end else begin
        out_c[wr[1:0]]  = comp_c[i];
        wr              = wr + 3'd1;
      end
    end
  end

  for (genvar g = 0; g < LINE_N; g++) begin : g_pack
    assign line_out[CELL_W*g +: CELL_W] = out_c[g];
  end

endmodule

// File: rtl/board_shift.sv
// 2048 move/merge engine: captures the board on a one-hot direction pulse,
// processes one line per cycle through a shared line_merge, then commits.
// Optional feature macro: BOARD_SHIFT_SCORE_EN (score_delta accounting).
module board_shift
  import game2048_pkg::*;
#(
  parameter int unsigned MAX_EXP = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               up,
  input  logic               down,
  input  logic               left,
  input  logic               right,
  input  logic [BOARD_W-1:0] board_in,
  output logic [BOARD_W-1:0] board_out,
  output logic               busy,
  output logic               done,
  output logic               moved,
  output logic [SCORE_W-1:0] score_delta
);

  state_e             state;
  dir_e               dir;
  logic [BOARD_W-1:0] work;
  logic [BOARD_W-1:0] captured;
  logic [BOARD_W-1:0] next_work;
  logic [LINE_W-1:0]  line_in;
  logic [LINE_W-1:0]  line_out;
  logic [1:0]         line_idx;
  logic [5:0]         cell_base [LINE_N];
  logic               dir_valid;

  assign dir_valid = $onehot({up, down, left, right});

  // Which line of the board the current state works on.
  always_comb begin
    case (state)
      LINE1:   line_idx = 2'd1;
      LINE2:   line_idx = 2'd2;
      LINE3:   line_idx = 2'd3;
      default: line_idx = 2'd0;
    endcase
  end

  // Bit offsets of the current line's cells, listed from the leading edge.
  always_comb begin
    logic [1:0] pos;
    pos = '0;
    for (int p = 0; p < LINE_N; p++) begin
      pos = 2'(p);
      case (dir)
        DIR_LEFT:  cell_base[p] = cell_off(line_idx, pos);
        DIR_RIGHT: cell_base[p] = cell_off(line_idx, ~pos);
        DIR_UP:    cell_base[p] = cell_off(pos, line_idx);
        default:   cell_base[p] = cell_off(~pos, line_idx);
      endcase
    end
  end

  // Gather the current line from the work register.
  always_comb begin
    line_in = '0;
    for (int p = 0; p < LINE_N; p++) begin
      line_in[CELL_W*p +: CELL_W] = work[cell_base[p] +: CELL_W];
    end
  end

  // Scatter the merged line back into the same cells.
  always_comb begin
    next_work = work;
    for (int p = 0; p < LINE_N; p++) begin
      next_work[cell_base[p] +: CELL_W] = line_out[CELL_W*p +: CELL_W];
    end
  end

`ifdef BOARD_SHIFT_SCORE_EN
  logic [LINE_SCORE_W-1:0] line_score;
  logic [SCORE_W-1:0]      score_acc;
`endif

  line_merge #(
    .MAX_EXP (MAX_EXP)
  ) u_line_merge (
    .line_in    (line_in),
    .line_out   (line_out)
`ifdef BOARD_SHIFT_SCORE_EN
    ,
    .line_score (line_score)
`endif
  );

  // Move sequencer: capture, four line passes, commit; outputs are registered here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      dir       <= DIR_LEFT;
      work      <= '0;
      captured  <= '0;
      board_out <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      moved     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (dir_valid) begin
            work     <= board_in;
            captured <= board_in;
            busy     <= 1'b1;
            state    <= LINE0;
            if (up)        dir <= DIR_UP;
            else if (down) dir <= DIR_DOWN;
            else if (left) dir <= DIR_LEFT;
            else           dir <= DIR_RIGHT;
          end
        end
        LINE0: begin
          work  <= next_work;
          state <= LINE1;
        end
        LINE1: begin
          work  <= next_work;
          state <= LINE2;
        end
        LINE2: begin
          work  <= next_work;
          state <= LINE3;
        end
        LINE3: begin
          work  <= next_work;
          state <= COMMIT;
        end
        COMMIT: begin
          board_out <= work;
          moved     <= (work != captured);
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BOARD_SHIFT_SCORE_EN
  // Score accumulator: cleared on capture, summed per line, published on commit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      score_acc   <= '0;
      score_delta <= '0;
    end else begin
      case (state)
        IDLE:                      if (dir_valid) score_acc <= '0;
        LINE0, LINE1, LINE2, LINE3: score_acc <= score_sat_add(score_acc, line_score);
        COMMIT:                    score_delta <= score_acc;
        default: ;
      endcase
    end
  end
`else
  assign score_delta = '0;
`endif

endmodule

// File: tb/tb_board_shift.sv
// Self-checking bench for board_shift: table of directed moves plus
// hand-written sequences for ignored pulses and mid-move reset.
module tb_board_shift;

  localparam logic [3:0] D_UP    = 4'b1000;
  localparam logic [3:0] D_DOWN  = 4'b0100;
  localparam logic [3:0] D_LEFT  = 4'b0010;
  localparam logic [3:0] D_RIGHT = 4'b0001;
  localparam int         N_VEC   = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
  logic [63:0] board_in = '0;
  logic [63:0] board_out;
  logic        busy, done, moved;
  logic [15:0] score_delta;

  typedef struct {
    logic [3:0]  dir;
    logic [63:0] b_in;
    logic [63:0] b_out;
    logic        mv;
    logic [15:0] sc;
  } vec_t;

  vec_t vecs [N_VEC];
  int   n_checks = 0;
  int   n_pass   = 0;

  board_shift dut (
    .clk         (clk),
    .rst         (rst),
    .up          (up),
    .down        (down),
    .left        (left),
    .right       (right),
    .board_in    (board_in),
    .board_out   (board_out),
    .busy        (busy),
    .done        (done),
    .moved       (moved),
    .score_delta (score_delta)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [15:0] exp_score(input logic [15:0] s);
`ifdef BOARD_SHIFT_SCORE_EN
    return s;
`else
    return (s & 16'h0000);
`endif
  endfunction

  // Pulse a direction for one cycle; returns at the falling edge after capture.
  task automatic start_move(input logic [3:0] d, input logic [63:0] b);
    @(negedge clk);
    {up, down, left, right} = d;
    board_in = b;
    @(negedge clk);
    {up, down, left, right} = 4'b0000;
    board_in = {$urandom, $urandom};
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int lat;
    start_move(v.dir, v.b_in);
    check({tag, " busy after capture"}, 64'(busy), 64'd1);
    wait_done(lat);
    check({tag, " done latency"}, 64'(lat), 64'd5);
    check({tag, " board_out"}, board_out, v.b_out);
    check({tag, " moved"}, 64'(moved), 64'(v.mv));
    check({tag, " score_delta"}, 64'(score_delta), 64'(exp_score(v.sc)));
    check({tag, " busy at done"}, 64'(busy), 64'd0);
    @(negedge clk);
    check({tag, " done one cycle"}, 64'(done), 64'd0);
  endtask

  initial begin
    int cnt;
    int lat;

    vecs[0] = '{D_LEFT,  64'h0000_0000_0000_2211, 64'h0000_0000_0000_0032, 1'b1, 16'd12};
    vecs[1] = '{D_RIGHT, 64'h0000_0000_0000_1111, 64'h0000_0000_0000_2200, 1'b1, 16'd8};
    vecs[2] = '{D_UP,    64'h0000_0001_0001_0001, 64'h0000_0000_0001_0002, 1'b1, 16'd4};
    vecs[3] = '{D_LEFT,  64'h0000_0000_0000_0001, 64'h0000_0000_0000_0001, 1'b0, 16'd0};
    vecs[4] = '{D_LEFT,  64'h0000_0000_0000_00FF, 64'h0000_0000_0000_000F, 1'b1, 16'hFFFF};
    vecs[5] = '{D_DOWN,  64'h0020_0020_0010_0010, 64'h0030_0020_0000_0000, 1'b1, 16'd12};
    vecs[6] = '{D_RIGHT, 64'h0000_2110_0000_0000, 64'h0000_2200_0000_0000, 1'b1, 16'd4};
    vecs[7] = '{D_LEFT,  64'h3030_4321_0101_1111, 64'h0004_4321_0002_0022, 1'b1, 16'd28};
    vecs[8] = '{D_UP,    64'h0000_0000_0000_4321, 64'h0000_0000_0000_4321, 1'b0, 16'd0};
    vecs[9] = '{D_LEFT,  64'h0000_0000_0000_2010, 64'h0000_0000_0000_0021, 1'b1, 16'd0};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset board_out", board_out, 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset moved", 64'(moved), 64'd0);
    check("reset score_delta", 64'(score_delta), 64'd0);
    rst = 1'b1;

    // Directed move table
    for (int i = 0; i < N_VEC; i++) begin
      run_vec($sformatf("v%0d", i), vecs[i]);
    end

    // Two directions at once: no capture, no done, board_out held
    @(negedge clk);
    {up, down, left, right} = D_UP | D_LEFT;
    board_in = 64'h0000_0000_0000_1111;
    @(negedge clk);
    {up, down, left, right} = 4'b0000;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (busy || done) cnt++;
      @(negedge clk);
    end
    check("multi-dir activity", 64'(cnt), 64'd0);
    check("multi-dir board_out held", board_out, vecs[N_VEC-1].b_out);

    // Direction pulse at E2 of a move is ignored
    start_move(D_LEFT, 64'h0000_0000_0000_1111);
    @(negedge clk);
    down = 1'b1;
    board_in = 64'h1000_1000_1000_1000;
    @(negedge clk);
    down = 1'b0;
    cnt = 0;
    for (int i = 0; i < 14; i++) begin
      if (done) cnt++;
      @(negedge clk);
    end
    check("ignored pulse done count", 64'(cnt), 64'd1);
    check("ignored pulse board_out", board_out, 64'h0000_0000_0000_0022);
    check("ignored pulse moved", 64'(moved), 64'd1);
    check("ignored pulse busy idle", 64'(busy), 64'd0);

    // Reset asserted at E3 abandons the move asynchronously
    start_move(D_RIGHT, 64'h0000_0000_0000_1111);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid-reset busy", 64'(busy), 64'd0);
    check("mid-reset done", 64'(done), 64'd0);
    check("mid-reset moved", 64'(moved), 64'd0);
    check("mid-reset board_out", board_out, 64'd0);
    check("mid-reset score_delta", 64'(score_delta), 64'd0);
    @(negedge clk);
    @(negedge clk);
    check("held reset no done", 64'(done), 64'd0);
    rst = 1'b1;

    // Normal move after reset release
    run_vec("post-reset", vecs[0]);

    // Back-to-back: next capture is accepted on the edge after done
    start_move(D_RIGHT, 64'h0000_0000_0000_1111);
    wait_done(lat);
    {up, down, left, right} = D_LEFT;
    board_in = 64'h0000_0000_0000_2211;
    @(negedge clk);
    {up, down, left, right} = 4'b0000;
    check("b2b first board_out", board_out, 64'h0000_0000_0000_2200);
    check("b2b second busy", 64'(busy), 64'd1);
    wait_done(lat);
    check("b2b second latency", 64'(lat), 64'd5);
    check("b2b second board_out", board_out, 64'h0000_0000_0000_0032);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/board_shift.md
# board_shift

Move/merge engine for the 2048 game datapath; the producer side of the board that the tile spawner consumes. On a one-hot direction pulse it captures the 64-bit board, slides and merges tiles one line per cycle, and publishes the new board with a `moved` flag. `moved` tells the spawner a new tile is due. A board with no legal change in the requested direction is returned unchanged with `moved` = 0.

## Interface
Parameters:
- `MAX_EXP`, default 15: largest storable tile exponent; merge results saturate here.

Ports:
- `clk`  in  1  system clock; all state on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `up`, `down`, `left`, `right`  in  1 each  debounced single-cycle direction pulses
- `board_in`  in  64  current board; cell i = 4*row+col (row 0 top, col 0 left) at bits [4i+3:4i]; 0 = empty, n = tile 2^n
- `board_out`  out  64  result board; holds last result between moves
- `busy`  out  1  high while a move is in flight
- `done`  out  1  one-cycle pulse when `board_out`/`moved` are updated
- `moved`  out  1  last move changed the board; held until next `done`
- `score_delta`  out  16  merge score of last move (only with `BOARD_SHIFT_SCORE_EN`)

## Operation
- FSM states: IDLE, LINE0, LINE1, LINE2, LINE3, COMMIT.
- IDLE: if exactly one direction input is high, latch `board_in` into the work register and the direction, set `busy`, go LINE0. Zero or ≥2 directions high: stay IDLE, no effect.
- LINEk: gather line k from work register in leading-edge order, apply `line_merge`, scatter back to the same cells.
  - left: row k, cols 0→3; right: row k, cols 3→0; up: col k, rows 0→3; down: col k, rows 3→0.
- `line_merge` (4 exponents, leading first):
  - compact non-zero cells toward the leading edge;
  - scan from the leading edge, merging equal adjacent pairs;
  - each tile merges at most once per move; `[1,1,1,1]` → `[2,2,0,0]`; `[2,1,1,0]` → `[2,2,0,0]`;
  - merged exponent = e+1, saturating at `MAX_EXP`.
- COMMIT: `board_out` ← work register; `moved` ← (work ≠ captured board); pulse `done`; clear `busy`; return to IDLE.
- Direction pulses while `busy` are ignored, not queued.
- Reset values: `board_out` = 0, `busy` = 0, `done` = 0, `moved` = 0, `score_delta` = 0, FSM = IDLE.
- Reset asserted mid-move: the move is abandoned and all outputs return to reset values immediately.

## Timing
- Capture edge E0 in IDLE; LINE0..LINE3 occupy edges E1..E4; COMMIT registers results at E5.
- `busy` is high from after E0 until after E5.
- `done` is high for exactly the cycle after E5.
- `board_in` is sampled only at E0; it may change freely afterward.
- Earliest next capture is the edge following `done`. A move therefore takes 6 cycles, capture to next acceptance.

## Configuration
- `BOARD_SHIFT_SCORE_EN` defined:
  - each merge producing exponent e+1 adds 2^(e+1) to the accumulator, saturating at 16'hFFFF;
  - the accumulator clears at E0;
  - `score_delta` is registered at COMMIT.
- Undefined: no accumulator is built, and `score_delta` is tied to 0.

## Structure
- Shared package `game2048_pkg`:
  - `CELL_W` = 4, `BOARD_W` = 64, `LINE_N` = 4;
  - direction enum (UP/DOWN/LEFT/RIGHT);
  - FSM state enum;
  - cell-index helper function (row, col → bit offset).
- One combinational sub-module, `line_merge`: 4×4-bit in, 4×4-bit out, plus per-line score (under the macro). It is instantiated once and reused across LINE states.

## Test plan
- `left` with `board_in` = 64'h0000_0000_0000_2211 → after 5 cycles `board_out` = 64'h0000_0000_0000_0032, `moved` = 1, `done` 1 cycle; `score_delta` = 12 with macro.
- `right` with 64'h0000_0000_0000_1111 → `board_out` = 64'h0000_0000_0000_2200, `moved` = 1, `score_delta` = 8.
- `up` with 64'h0000_0001_0001_0001 → `board_out` = 64'h0000_0000_0001_0002, `moved` = 1.
- `left` with 64'h0000_0000_0000_0001 → `board_out` unchanged, `moved` = 0, `done` still pulses. `left` with 64'h0000_0000_0000_00FF → `board_out` = 64'h0000_0000_0000_000F; `score_delta` = 16'hFFFF with macro.
- `up`+`left` high together → `busy` stays 0, no `done`. `down` pulse at E2 of an active move → ignored; exactly one `done`.
- Assert `rst` low at E3 → `busy`, `done`, `moved` = 0 and `board_out` = 0 asynchronously. After release, a new `left` completes normally.
